fp_exp_align: RTL
=================

Name: fp_exp_align

Overview:
- Sequential FP32 pre-add/sub alignment stage that sits directly upstream of the mantissa subtractor datapath.
- Accepts two IEEE-754 single-precision operands over a valid/ready handshake.
- Computes the exponent difference bit-serially through a one-bit full-subtractor cell with a registered borrow, and orders the operands (big/small).
- Right-shifts the small mantissa one bit per cycle, with guard/round/sticky, before presenting the aligned pair downstream.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width; internal mantissa is MAN_W+1 (hidden bit) plus 3 GRS bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  32  operand A, FP32.
- b  in  32  operand B, FP32.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts result.
- swapped  out  1  1 when B has the larger exponent.
- sign_big  out  1  sign of larger-exponent operand.
- sign_small  out  1  sign of the other operand.
- exp_big  out  8  effective exponent of the larger operand.
- exp_diff  out  8  |eff_exp_a − eff_exp_b|.
- mant_big  out  27  {hidden, fraction, 3'b000}.
- mant_small  out  27  aligned small mantissa, bit 0 is sticky.
- special  out  1  NaN/Inf operand detected (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset: state IDLE; in_ready=1; out_valid=0; all data outputs and special=0; borrow reg=0. rst_n low in any state aborts the operation; the next cycle is IDLE with no output.
- Effective exponent: eff_exp = (exp==0) ? 1 : exp. Hidden bit = (exp!=0).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture both operands, clear borrow and bit counter → SUB.
- SUB (8 cycles):
  - Each cycle, bit i (LSB first) of eff_exp_a − eff_exp_b goes through the one-bit subtractor cell.
  - The borrow register feeds Bin; D shifts into the diff register.
  - After bit 7:
    - final borrow=1 → swapped=1, go to NEG.
    - final borrow=0 → go to SHIFT.
  - Equal exponents give swapped=0.
- NEG (8 cycles): serial 0 − diff using the same cell and a cleared borrow, producing a positive magnitude → SHIFT.
- SHIFT:
  - Shift count n = min(exp_diff, 27).
  - Each cycle, shift the small mantissa right 1; the shifted-out bit ORs into bit 0 (sticky).
  - When n=0, spend zero cycles and go to DONE directly.
- DONE:
  - out_valid=1; outputs stable until out_valid&out_ready, then → IDLE.
  - in_ready=0 in every state except IDLE. There is no same-cycle re-accept (one bubble).
- Latency: handshake at cycle 0.
  - No swap: out_valid first high at cycle 9+n.
  - Swap: out_valid first high at cycle 17+n.
  - Worst case is 44.
- Width rules: exp_diff is mod-2^8 during serial ops. The final magnitude is ≤254, so there is no overflow.

Optional Feature:
- Macro: FP_EXP_ALIGN_SPECIAL_EN.
- Defined:
  - At capture, if either exponent == 8'hFF, go directly to DONE (out_valid at cycle 1).
  - Outputs: special=1, exp_diff=0, swapped=0, mants unshifted.
- Undefined:
  - special tied 0.
  - 8'hFF exponents are processed as ordinary values.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, MAN_W, GRS_W=3, and MANT_EXT_W=27.
  - SHIFT_CAP=27.
  - The state enum {IDLE, SUB, NEG, SHIFT, DONE}.
  - The fp32 field-slice typedef.
- One sub-module: the existing one-bit full_sub cell, instantiated once and shared by SUB and NEG via input muxing.

Test Plan:
- Normal, no swap: a=0x40400000, b=0x3F800000 → swapped=0, exp_big=0x80, exp_diff=1, mant_big=0x6000000, mant_small=0x2000000; out_valid at cycle 10.
- Swap: a=0x3F800000, b=0x40400000 → swapped=1, exp_diff=1, sign_big=0, mant_small=0x2000000; out_valid at cycle 18.
- Sticky: a=0x4B000000, b=0x3F800001 → exp_diff=23, mant_small=0x0000009.
- Shift cap: a=0x64000000 (exp 200), b=0x3F800000 → exp_diff=73, mant_small=27'h1; out_valid at cycle 36.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0.
  - Separately, pulse rst_n=0 at cycle 4 of SUB → next cycle in_ready=1, out_valid=0.
- Macro defined: a=0x7F800000, b=0x3F800000 → special=1, out_valid at cycle 1, exp_diff=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types, widths and helpers for the FP32 exponent-alignment stage.
package fp_pkg;

  localparam int unsigned EXP_W      = 8;
  localparam int unsigned MAN_W      = 23;
  localparam int unsigned GRS_W      = 3;
  localparam int unsigned MANT_EXT_W = MAN_W + 1 + GRS_W;
  localparam int unsigned SHIFT_CAP  = 27;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    NEG,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  // Denormals use exponent 1 for alignment purposes.
  function automatic logic [EXP_W-1:0] eff_exp(input fp32_t f);
    return (f.exp == '0) ? EXP_W'(1) : f.exp;
  endfunction

  // {hidden, fraction, guard, round, sticky}
  function automatic logic [MANT_EXT_W-1:0] ext_mant(input fp32_t f);
    return {(f.exp != '0), f.frac, {GRS_W{1'b0}}};
  endfunction

  // Beyond SHIFT_CAP every bit has already collapsed into sticky.
  function automatic logic [CNT_W-1:0] shift_count(input logic [EXP_W-1:0] d);
    return (d > EXP_W'(SHIFT_CAP)) ? CNT_W'(SHIFT_CAP) : d[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/fp_exp_align_full_sub.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Combinational difference and borrow.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/fp_exp_align.sv
// FP32 pre-add/sub alignment: bit-serial exponent difference, operand
// ordering and one-bit-per-cycle right shift of the small mantissa with GRS.
// Optional macro FP_EXP_ALIGN_SPECIAL_EN: short-circuit NaN/Inf operands.
module fp_exp_align
  import fp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MAN_W:0]  a,
  input  logic [EXP_W+MAN_W:0]  b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  swapped,
  output logic                  sign_big,
  output logic                  sign_small,
  output logic [EXP_W-1:0]      exp_big,
  output logic [EXP_W-1:0]      exp_diff,
  output logic [MANT_EXT_W-1:0] mant_big,
  output logic [MANT_EXT_W-1:0] mant_small,
  output logic                  special
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  borrow_q, borrow_d;
  logic [EXP_W-1:0]      diff_q, diff_d;
  logic                  swapped_q, swapped_d;
  logic                  sign_big_q, sign_big_d;
  logic                  sign_small_q, sign_small_d;
  logic [EXP_W-1:0]      exp_big_q, exp_big_d;
  logic [EXP_W-1:0]      exp_small_q, exp_small_d;
  logic [MANT_EXT_W-1:0] mant_big_q, mant_big_d;
  logic [MANT_EXT_W-1:0] mant_small_q, mant_small_d;

  fp32_t            fa, fb;
  logic             cell_a, cell_b, cell_d, cell_bout;
  logic [EXP_W-1:0] diff_shift;
  logic [CNT_W-1:0] n_shift;
  logic             last_bit;

  assign fa = fp32_t'(a);
  assign fb = fp32_t'(b);

  // SUB feeds the captured exponent bits; NEG computes 0 - diff by feeding
  // the diff register's LSB while it rotates back in from the top.
  always_comb begin
    cell_a = 1'b0;
    cell_b = diff_q[0];
    if (state_q == SUB) begin
      cell_a = exp_big_q[cnt_q[2:0]];
      cell_b = exp_small_q[cnt_q[2:0]];
    end
  end

  full_sub u_full_sub (
    .a    (cell_a),
    .b    (cell_b),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign diff_shift = {cell_d, diff_q[EXP_W-1:1]};
  assign n_shift    = shift_count(diff_shift);
  assign last_bit   = (cnt_q == CNT_W'(EXP_W - 1));

`ifdef FP_EXP_ALIGN_SPECIAL_EN
  logic special_q, special_d;
  assign special = special_q;
`else
  assign special = 1'b0;
`endif

  // State register and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      swapped_q    <= 1'b0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      exp_big_q    <= '0;
      exp_small_q  <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
`ifdef FP_EXP_ALIGN_SPECIAL_EN
      special_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      swapped_q    <= swapped_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      exp_big_q    <= exp_big_d;
      exp_small_q  <= exp_small_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
`ifdef FP_EXP_ALIGN_SPECIAL_EN
      special_q    <= special_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    swapped_d    = swapped_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    exp_big_d    = exp_big_q;
    exp_small_d  = exp_small_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
`ifdef FP_EXP_ALIGN_SPECIAL_EN
    special_d    = special_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // A is provisionally "big"; swapped at the end of SUB if needed.
          cnt_d        = '0;
          borrow_d     = 1'b0;
          diff_d       = '0;
          swapped_d    = 1'b0;
          sign_big_d   = fa.sign;
          sign_small_d = fb.sign;
          exp_big_d    = eff_exp(fa);
          exp_small_d  = eff_exp(fb);
          mant_big_d   = ext_mant(fa);
          mant_small_d = ext_mant(fb);
          state_d      = SUB;
`ifdef FP_EXP_ALIGN_SPECIAL_EN
          special_d    = 1'b0;
          if ((fa.exp == '1) || (fb.exp == '1)) begin
            special_d = 1'b1;
            state_d   = DONE;
          end
`endif
        end
      end

      SUB: begin
        borrow_d = cell_bout;
        diff_d   = diff_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          if (cell_bout) begin
            swapped_d    = 1'b1;
            sign_big_d   = sign_small_q;
            sign_small_d = sign_big_q;
            exp_big_d    = exp_small_q;
            exp_small_d  = exp_big_q;
            mant_big_d   = mant_small_q;
            mant_small_d = mant_big_q;
            borrow_d     = 1'b0;
            cnt_d        = '0;
            state_d      = NEG;
          end else begin
            cnt_d   = n_shift;
            state_d = (n_shift == '0) ? DONE : SHIFT;
          end
        end
      end

      NEG: begin
        borrow_d = cell_bout;
        diff_d   = diff_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          borrow_d = 1'b0;
          cnt_d    = n_shift;
          state_d  = (n_shift == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        mant_small_d = {1'b0, mant_small_q[MANT_EXT_W-1:2],
                        mant_small_q[1] | mant_small_q[0]};
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign swapped    = swapped_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign exp_big    = exp_big_q;
  assign exp_diff   = diff_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;

endmodule
